// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vote_session_ctrl
//  Description : Session controller for the seven-judge majority vote.
//                A start pulse opens a collection window. The first vote
//                from each judge is latched. The window closes when all
//                seven judges have voted, or when TIMEOUT_CYC cycles have
//                elapsed. The yes votes are then tallied against THRESHOLD,
//                and the result is held until clear (or a new start).
//                A judge that never votes counts as "no".
//  Ports       :
//      clk        - system clock, rising edge
//      rst        - asynchronous active-high reset
//      start      - one-cycle pulse; opens a session (IDLE or RESULT)
//      clear      - one-cycle pulse; RESULT -> IDLE
//      vote_en    - bit i: judge i presents a vote this cycle
//      vote_val   - bit i: judge i's vote value (1 = yes)
//      busy       - high in COLLECT or TALLY
//      done       - high in RESULT
//      pass       - yes_count >= THRESHOLD (valid while done)
//      yes_count  - number of yes votes (valid while done)
//      voted      - bit i: judge i's vote has been latched this session
//      timed_out  - window closed by timeout with a judge missing
//  Revision    : 1.0 - initial release
// ============================================================================
module vote_session_ctrl #(
    parameter int THRESHOLD   = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic [6:0] vote_en,
    input  logic [6:0] vote_val,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] yes_count,
    output logic [6:0] voted,
    output logic       timed_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_TALLY   = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       c_THRESH   = 4'(THRESHOLD);
    localparam logic [6:0]       c_ALL      = 7'h7F;

    state_t           r_state;
    logic [6:0]       r_voted;
    logic [6:0]       r_yes;
    logic [TMR_W-1:0] r_timer;
    logic             r_pass;
    logic [2:0]       r_yes_count;
    logic             r_timed_out;

    logic [6:0]       w_new_mask;
    logic [6:0]       w_voted_nxt;
    logic [6:0]       w_yes_nxt;
    logic [2:0]       w_pop;
    logic             w_pass;
    logic             w_exit;

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < 7; i++) begin
            sum = sum + {2'b00, v[i]};
        end
        return sum;
    endfunction

    always_comb begin
        // Only judges that have not yet voted may latch a value.
        w_new_mask  = vote_en & ~r_voted;
        w_voted_nxt = r_voted | w_new_mask;
        w_yes_nxt   = (r_yes & ~w_new_mask) | (vote_val & w_new_mask);
        w_pop       = popcount7(r_yes);
        w_pass      = ({1'b0, w_pop} >= c_THRESH);
        // All-voted uses the registered mask, so the window ends one
        // cycle after the edge that captured the last vote.
        w_exit      = (r_voted == c_ALL) || (r_timer == c_TMR_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_voted     <= 7'd0;
            r_yes       <= 7'd0;
            r_timer     <= '0;
            r_pass      <= 1'b0;
            r_yes_count <= 3'd0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_COLLECT;
                        r_voted     <= 7'd0;
                        r_yes       <= 7'd0;
                        r_timer     <= '0;
                        r_pass      <= 1'b0;
                        r_yes_count <= 3'd0;
                        r_timed_out <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    r_voted <= w_voted_nxt;
                    r_yes   <= w_yes_nxt;
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_exit) begin
                        r_state     <= ST_TALLY;
                        // An all-voted exit always leaves the mask full,
                        // so this also covers simultaneous exit causes.
                        r_timed_out <= (w_voted_nxt != c_ALL);
                    end
                end
                ST_TALLY: begin
                    r_yes_count <= w_pop;
                    r_pass      <= w_pass;
                    r_state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (start) begin
                        r_state     <= ST_COLLECT;
                        r_voted     <= 7'd0;
                        r_yes       <= 7'd0;
                        r_timer     <= '0;
                        r_pass      <= 1'b0;
                        r_yes_count <= 3'd0;
                        r_timed_out <= 1'b0;
                    end else if (clear) begin
                        r_state     <= ST_IDLE;
                        r_voted     <= 7'd0;
                        r_yes       <= 7'd0;
                        r_timer     <= '0;
                        r_pass      <= 1'b0;
                        r_yes_count <= 3'd0;
                        r_timed_out <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_COLLECT) || (r_state == ST_TALLY);
    assign done      = (r_state == ST_RESULT);
    assign pass      = r_pass;
    assign yes_count = r_yes_count;
    assign voted     = r_voted;
    assign timed_out = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_session_ctrl
//  Description : Directed testbench for vote_session_ctrl. Stimulus pushes
//                the expected result of each session into a queue. A
//                monitor pops an entry on every rising edge of done and
//                compares the result fields and the cycle on which done rose.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_session_ctrl;

    localparam int THR = 4;
    localparam int TO  = 8;
    localparam int TW  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clear;
    logic [6:0] vote_en;
    logic [6:0] vote_val;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] yes_count;
    logic [6:0] voted;
    logic       timed_out;

    vote_session_ctrl #(
        .THRESHOLD   (THR),
        .TIMEOUT_CYC (TO),
        .TMR_W       (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .vote_en   (vote_en),
        .vote_val  (vote_val),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .yes_count (yes_count),
        .voted     (voted),
        .timed_out (timed_out)
    );

    always #5 clk = ~clk;

    // Rising-edge counter: after edge N, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] yc;
        logic       pass;
        logic       to;
        logic [6:0] voted;
        int         dedge;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   s_edge = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per result presentation.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cyc %0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("yes_count",  32'(yes_count), 32'(mon_e.yc));
                chk("pass",       32'(pass),      32'(mon_e.pass));
                chk("timed_out",  32'(timed_out), 32'(mon_e.to));
                chk("voted",      32'(voted),     32'(mon_e.voted));
                chk("done_cycle", 32'(cyc),       32'(mon_e.dedge));
            end
        end
        prev_done <= done;
    end

    function automatic exp_t mk(input logic [2:0] yc, input logic p, input logic to,
                                input logic [6:0] v, input int de);
        exp_t e;
        e.yc = yc; e.pass = p; e.to = to; e.voted = v; e.dedge = de;
        return e;
    endfunction

    // Called at a negedge; start is sampled at edge cyc+1.
    task automatic do_start();
        start  = 1'b1;
        s_edge = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at a negedge; the vote is captured at edge cyc+1.
    task automatic pulse_vote(input logic [6:0] en, input logic [6:0] val);
        vote_en  = en;
        vote_val = val;
        @(negedge clk);
        vote_en  = 7'd0;
        vote_val = 7'd0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=pending required=done", name);
            sb_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"},  32'(busy),      32'd0);
        chk({name, "_done"},  32'(done),      32'd0);
        chk({name, "_pass"},  32'(pass),      32'd0);
        chk({name, "_yc"},    32'(yes_count), 32'd0);
        chk({name, "_voted"}, 32'(voted),     32'd0);
        chk({name, "_to"},    32'(timed_out), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        clear    = 1'b0;
        vote_en  = 7'd0;
        vote_val = 7'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Session 1: judges 0..6 one per cycle, 0-3 yes. Last capture at S+7.
        do_start();
        chk("s1_busy", 32'(busy), 32'd1);
        sb_q.push_back(mk(3'd4, 1'b1, 1'b0, 7'h7F, s_edge + 9));
        for (int i = 0; i < 7; i++) begin
            pulse_vote(7'(1 << i), (i < 4) ? 7'(1 << i) : 7'd0);
        end
        wait_drain("s1", 20);
        pulse_clear();
        chk_all_zero("clear1");

        // Session 2: all seven at once, three yes. TALLY at S+2, done at S+3.
        do_start();
        sb_q.push_back(mk(3'd3, 1'b0, 1'b0, 7'h7F, s_edge + 3));
        pulse_vote(7'h7F, 7'b0000111);
        chk("s2_voted_collect", 32'(voted), 32'h7F);
        chk("s2_busy",          32'(busy),  32'd1);
        wait_drain("s2", 20);

        // Session 3 (started straight from RESULT): timeout with three votes.
        // 8 COLLECT cycles from edge S, TALLY from S+8, done from S+9.
        do_start();
        sb_q.push_back(mk(3'd3, 1'b0, 1'b1, 7'h07, s_edge + 9));
        pulse_vote(7'h07, 7'h07);
        wait_drain("s3", 20);

        // Session 4: judge 5 votes yes, then tries no; second vote ignored.
        do_start();
        sb_q.push_back(mk(3'd4, 1'b1, 1'b0, 7'h7F, s_edge + 6));
        pulse_vote(7'b0100111, 7'b0100111);
        @(negedge clk);
        pulse_vote(7'b0100000, 7'b0000000);
        pulse_vote(7'b1011000, 7'b0000000);
        wait_drain("s4", 20);

        // Session 5: start and clear together in RESULT -> start wins.
        start  = 1'b1;
        clear  = 1'b1;
        s_edge = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        clear  = 1'b0;
        chk("s5_busy",  32'(busy),      32'd1);
        chk("s5_done",  32'(done),      32'd0);
        chk("s5_voted", 32'(voted),     32'd0);
        chk("s5_yc",    32'(yes_count), 32'd0);
        // Last judge votes on the final window cycle (edge S+8) and is counted.
        sb_q.push_back(mk(3'd7, 1'b1, 1'b0, 7'h7F, s_edge + 9));
        pulse_vote(7'b0111111, 7'b0111111);
        repeat (6) @(negedge clk);
        pulse_vote(7'b1000000, 7'b1000000);
        wait_drain("s5", 20);
        pulse_clear();
        chk_all_zero("clear5");

        // Session 6: asynchronous reset mid-COLLECT with three votes latched.
        do_start();
        pulse_vote(7'b0000111, 7'b0000101);
        chk("s6_voted_pre", 32'(voted), 32'h07);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        pulse_vote(7'h7F, 7'h7F);
        pulse_vote(7'h7F, 7'h7F);
        chk_all_zero("idle_votes");

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
